// File: rtl/core_sfr_bank_if.sv
// Core-FSM access bus for core_sfr_bank: strobes, address, write data and read return.
// Handshake: wr_b/rd_b are active-low single-cycle strobes; rd_valid pulses one cycle after every read.
interface core_sfr_bank_if #(
    parameter int ADDR_W = 8
);
    logic              sfr_bank_wr_b_i;
    logic              sfr_bank_rd_b_i;
    logic              sfr_bank_bit_byte_flag_i;
    logic [ADDR_W-1:0] sfr_bank_addr_i;
    logic [7:0]        sfr_bank_data_i;
    logic [7:0]        sfr_bank_data_o;
    logic              sfr_bank_rd_valid_o;
    logic              sfr_bank_hit_o;

    modport master (
        output sfr_bank_wr_b_i, sfr_bank_rd_b_i, sfr_bank_bit_byte_flag_i,
               sfr_bank_addr_i, sfr_bank_data_i,
        input  sfr_bank_data_o, sfr_bank_rd_valid_o, sfr_bank_hit_o
    );

    modport slave (
        input  sfr_bank_wr_b_i, sfr_bank_rd_b_i, sfr_bank_bit_byte_flag_i,
               sfr_bank_addr_i, sfr_bank_data_i,
        output sfr_bank_data_o, sfr_bank_rd_valid_o, sfr_bank_hit_o
    );
endinterface

// File: rtl/core_sfr_bank.sv
// Parametrised bit-addressable SFR bank with hardware set/clear and a timed-access unlock FSM.
// Optional macro CORE_SFR_BANK_RDCLR_EN: byte reads clear bits flagged by a sticky hw-set shadow.
module core_sfr_bank #(
    parameter int                      NUM_REGS  = 4,
    parameter int                      ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = ADDR_W'(8'hC0),
    parameter logic [8*NUM_REGS-1:0]   RESET_VAL = {NUM_REGS{8'h00}},
    parameter logic [NUM_REGS-1:0]     PROT_MASK = {NUM_REGS{1'b0}},
    parameter logic [ADDR_W-1:0]       TA_ADDR   = ADDR_W'(8'hC7),
    parameter int                      TA_WINDOW = 4
) (
    input  logic                    sfr_bank_clk_i,
    input  logic                    sfr_bank_reset_i,
    core_sfr_bank_if.slave          bus,
    input  logic [8*NUM_REGS-1:0]   sfr_bank_hw_set_i,
    input  logic [8*NUM_REGS-1:0]   sfr_bank_hw_clr_i,
    output logic [8*NUM_REGS-1:0]   sfr_bank_regs_o,
    output logic                    sfr_bank_ta_open_o,
    output logic                    sfr_bank_prot_viol_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_KEY1, ST_OPEN} ta_state_e;

    localparam logic [3:0] WIN = 4'(TA_WINDOW);

    ta_state_e             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [8*NUM_REGS-1:0] regs_q, regs_d;
    logic [7:0]            data_q, data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  hit_q, hit_d;
    logic                  viol_q, viol_d;

    logic                  wr, rd, is_bit, rd_hit, key_wr, prot_hit, sw_wr_ok;
    logic [2:0]            bit_sel;
    logic [ADDR_W-1:0]     slot_addr;
    logic [NUM_REGS-1:0]   hit_vec;
    logic [7:0]            rd_byte, din;
    logic [3:0]            cnt_dec;
    logic [8*NUM_REGS-1:0] rdclr;

    always_comb begin
        wr        = ~bus.sfr_bank_wr_b_i;
        rd        = ~bus.sfr_bank_rd_b_i;
        is_bit    = bus.sfr_bank_bit_byte_flag_i;
        din       = bus.sfr_bank_data_i;
        bit_sel   = bus.sfr_bank_addr_i[2:0];
        slot_addr = is_bit ? {bus.sfr_bank_addr_i[ADDR_W-1:3], 3'b000} : bus.sfr_bank_addr_i;
        hit_vec   = '0;
        rd_byte   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (slot_addr == BASE_ADDR + ADDR_W'(8 * k)) begin
                hit_vec[k] = 1'b1;
                rd_byte    = regs_q[8*k +: 8];
            end
        end
        key_wr   = wr && !is_bit && (bus.sfr_bank_addr_i == TA_ADDR);
        rd_hit   = (|hit_vec) && !(!is_bit && bus.sfr_bank_addr_i == TA_ADDR);
        prot_hit = |(hit_vec & PROT_MASK);
        sw_wr_ok = wr && !(prot_hit && state_q != ST_OPEN);
        cnt_dec  = cnt_q - 4'd1;
    end

    // Read path samples regs_q, so a same-cycle write is never visible to the read.
    always_comb begin
        rd_valid_d = rd;
        data_d     = data_q;
        hit_d      = hit_q;
        if (rd) begin
            data_d = '0;
            hit_d  = 1'b0;
            if (rd_hit) begin
                hit_d  = 1'b1;
                data_d = is_bit ? {7'b0, rd_byte[bit_sel]} : rd_byte;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        viol_d  = wr && prot_hit && (state_q != ST_OPEN);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (key_wr && din == 8'hAA) begin
                    state_d = ST_KEY1;
                    cnt_d   = WIN;
                end
            end
            ST_KEY1: begin
                if (key_wr && din == 8'hAA) begin
                    cnt_d = WIN;
                end else if (key_wr && din == 8'h55) begin
                    state_d = ST_OPEN;
                    cnt_d   = WIN;
                end else if (wr || cnt_dec == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_OPEN: begin
                if (wr && prot_hit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (key_wr && din == 8'hAA) begin
                    state_d = ST_KEY1;
                    cnt_d   = WIN;
                end else if (cnt_dec == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CORE_SFR_BANK_RDCLR_EN
    logic [8*NUM_REGS-1:0] shadow_q, shadow_d;

    // A same-cycle hw_set keeps both the bit and its shadow armed.
    always_comb begin
        rdclr = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd && !is_bit && rd_hit && hit_vec[k]) begin
                rdclr[8*k +: 8] = shadow_q[8*k +: 8] & ~sfr_bank_hw_set_i[8*k +: 8];
            end
        end
        shadow_d = (shadow_q & ~rdclr) | sfr_bank_hw_set_i;
    end

    always_ff @(posedge sfr_bank_clk_i) begin
        if (sfr_bank_reset_i) shadow_q <= '0;
        else                  shadow_q <= shadow_d;
    end
`else
    always_comb rdclr = '0;
`endif

    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (rdclr[8*k+b]) regs_d[8*k+b] = 1'b0;
                if (sw_wr_ok && hit_vec[k] && (!is_bit || bit_sel == 3'(b)))
                    regs_d[8*k+b] = is_bit ? din[0] : din[b];
                if (sfr_bank_hw_clr_i[8*k+b]) regs_d[8*k+b] = 1'b0;
                if (sfr_bank_hw_set_i[8*k+b]) regs_d[8*k+b] = 1'b1;
            end
        end
    end

    always_ff @(posedge sfr_bank_clk_i) begin
        if (sfr_bank_reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            regs_q     <= RESET_VAL;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            viol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            regs_q     <= regs_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
            viol_q     <= viol_d;
        end
    end

    assign bus.sfr_bank_data_o     = data_q;
    assign bus.sfr_bank_rd_valid_o = rd_valid_q;
    assign bus.sfr_bank_hit_o      = hit_q;
    assign sfr_bank_regs_o         = regs_q;
    assign sfr_bank_ta_open_o      = (state_q == ST_OPEN);
    assign sfr_bank_prot_viol_o    = viol_q;
endmodule

// File: tb/tb_core_sfr_bank.sv
// Self-checking bench for core_sfr_bank: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the bank.
module tb_core_sfr_bank;
    localparam logic [31:0] RV = 32'h3C5A_005A;
    localparam logic [3:0]  PM = 4'b0100;
    localparam int          TW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hw_set = '0;
    logic [31:0] hw_clr = '0;
    logic [31:0] regs_o;
    logic        ta_open_o, viol_o;
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    core_sfr_bank_if #(.ADDR_W(8)) bus ();

    core_sfr_bank #(
        .NUM_REGS(4), .ADDR_W(8), .BASE_ADDR(8'hC0), .RESET_VAL(RV),
        .PROT_MASK(PM), .TA_ADDR(8'hC7), .TA_WINDOW(TW)
    ) dut (
        .sfr_bank_clk_i(clk),
        .sfr_bank_reset_i(rst),
        .bus(bus),
        .sfr_bank_hw_set_i(hw_set),
        .sfr_bank_hw_clr_i(hw_clr),
        .sfr_bank_regs_o(regs_o),
        .sfr_bank_ta_open_o(ta_open_o),
        .sfr_bank_prot_viol_o(viol_o)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_regs [4];
    logic [7:0]  m_data;
    logic        m_hit, m_valid, m_viol;
    int          key_left, open_left;
    logic [31:0] m_shadow;

    function automatic logic [31:0] m_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    always @(posedge clk) begin : model
        logic       w, r, bt, unlocked, prot, sw_ok, nv;
        logic [7:0] a, d, base;
        logic [7:0] nregs [4];
        logic [31:0] cleared;
        int slot;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_regs[k] = RV[8*k +: 8];
            m_data = 8'h00; m_hit = 1'b0; m_valid = 1'b0; m_viol = 1'b0;
            key_left = 0; open_left = 0; m_shadow = '0;
        end else begin
            w  = !bus.sfr_bank_wr_b_i;
            r  = !bus.sfr_bank_rd_b_i;
            bt = bus.sfr_bank_bit_byte_flag_i;
            a  = bus.sfr_bank_addr_i;
            d  = bus.sfr_bank_data_i;
            base = bt ? (a & 8'hF8) : a;
            slot = -1;
            if (base >= 8'hC0 && base < 8'hE0 && base[2:0] == 3'd0) slot = (int'(base) - 'hC0) / 8;
            m_valid = r;
            if (r) begin
                if (slot >= 0) begin
                    m_hit  = 1'b1;
                    m_data = bt ? {7'b0, m_regs[slot][a[2:0]]} : m_regs[slot];
                end else begin
                    m_hit  = 1'b0;
                    m_data = 8'h00;
                end
            end
            unlocked = open_left > 0;
            prot     = (slot >= 0) && PM[slot];
            m_viol   = w && prot && !unlocked;
            sw_ok    = w && (slot >= 0) && !(prot && !unlocked);
            cleared  = '0;
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 8; b++) begin
                    nv = m_regs[k][b];
`ifdef CORE_SFR_BANK_RDCLR_EN
                    if (r && !bt && slot == k && m_shadow[8*k+b] && !hw_set[8*k+b]) begin
                        nv = 1'b0;
                        cleared[8*k+b] = 1'b1;
                    end
`endif
                    if (sw_ok && slot == k && (!bt || int'(a[2:0]) == b)) nv = bt ? d[0] : d[b];
                    if (hw_clr[8*k+b]) nv = 1'b0;
                    if (hw_set[8*k+b]) nv = 1'b1;
                    nregs[k][b] = nv;
                end
            end
            for (int k = 0; k < 4; k++) m_regs[k] = nregs[k];
            m_shadow = (m_shadow & ~cleared) | hw_set;
            // unlock sequencing as remaining-cycle budgets
            if (open_left > 0) begin
                if (w && prot) open_left = 0;
                else if (w && !bt && a == 8'hC7 && d == 8'hAA) begin open_left = 0; key_left = TW; end
                else open_left = open_left - 1;
            end else if (key_left > 0) begin
                if (w && !bt && a == 8'hC7 && d == 8'hAA) key_left = TW;
                else if (w && !bt && a == 8'hC7 && d == 8'h55) begin key_left = 0; open_left = TW; end
                else if (w) key_left = 0;
                else key_left = key_left - 1;
            end else if (w && !bt && a == 8'hC7 && d == 8'hAA) begin
                key_left = TW;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("regs", regs_o, m_pack());
            check("ta_open", 32'(ta_open_o), 32'(open_left > 0));
            check("prot_viol", 32'(viol_o), 32'(m_viol));
            check("rd_valid", 32'(bus.sfr_bank_rd_valid_o), 32'(m_valid));
            check("data", 32'(bus.sfr_bank_data_o), 32'(m_data));
            check("hit", 32'(bus.sfr_bank_hit_o), 32'(m_hit));
        end
    end

    // ---------------- driver ----------------
    task automatic op(input logic w, input logic r, input logic b,
                      input logic [7:0] a, input logic [7:0] d);
        bus.sfr_bank_wr_b_i          = ~w;
        bus.sfr_bank_rd_b_i          = ~r;
        bus.sfr_bank_bit_byte_flag_i = b;
        bus.sfr_bank_addr_i          = a;
        bus.sfr_bank_data_i          = d;
        @(posedge clk);
        #1;
        bus.sfr_bank_wr_b_i = 1'b1;
        bus.sfr_bank_rd_b_i = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        bus.sfr_bank_wr_b_i = 1'b1;
        bus.sfr_bank_rd_b_i = 1'b1;
        bus.sfr_bank_bit_byte_flag_i = 1'b0;
        bus.sfr_bank_addr_i = '0;
        bus.sfr_bank_data_i = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(1);
        rst = 1'b0;
        check("reset_regs", regs_o, 32'h3C5A005A);
        check("reset_ta_open", 32'(ta_open_o), 32'd0);
        check("reset_rd_valid", 32'(bus.sfr_bank_rd_valid_o), 32'd0);

        // byte reads of every slot, then a miss
        op(1'b0, 1'b1, 1'b0, 8'hC0, 8'h00);
        check("rd_slot0", 32'(bus.sfr_bank_data_o), 32'h5A);
        check("rd_slot0_valid", 32'(bus.sfr_bank_rd_valid_o), 32'd1);
        check("rd_slot0_hit", 32'(bus.sfr_bank_hit_o), 32'd1);
        op(1'b0, 1'b1, 1'b0, 8'hC8, 8'h00);
        check("rd_slot1", 32'(bus.sfr_bank_data_o), 32'h00);
        op(1'b0, 1'b1, 1'b0, 8'hD0, 8'h00);
        check("rd_slot2", 32'(bus.sfr_bank_data_o), 32'h5A);
        op(1'b0, 1'b1, 1'b0, 8'hD8, 8'h00);
        check("rd_slot3", 32'(bus.sfr_bank_data_o), 32'h3C);
        op(1'b0, 1'b1, 1'b0, 8'hC1, 8'h00);
        check("rd_miss_data", 32'(bus.sfr_bank_data_o), 32'h00);
        check("rd_miss_hit", 32'(bus.sfr_bank_hit_o), 32'd0);
        check("rd_miss_valid", 32'(bus.sfr_bank_rd_valid_o), 32'd1);
        idle(1);
        check("rd_valid_drop", 32'(bus.sfr_bank_rd_valid_o), 32'd0);
        check("data_hold", 32'(bus.sfr_bank_data_o), 32'h00);

        // bit write and bit read
        op(1'b1, 1'b0, 1'b1, 8'hCB, 8'h01);
        check("bitwr_slot1", 32'(regs_o[15:8]), 32'h08);
        check("model_slot1", 32'(m_regs[1]), 32'h08);
        op(1'b0, 1'b1, 1'b1, 8'hCB, 8'h00);
        check("bitrd", 32'(bus.sfr_bank_data_o), 32'h01);

        // simultaneous read and write of the same byte
        op(1'b1, 1'b1, 1'b0, 8'hC8, 8'h77);
        check("rdwr_data", 32'(bus.sfr_bank_data_o), 32'h08);
        check("rdwr_reg", 32'(regs_o[15:8]), 32'h77);

        // hw_set beats software write; hw_set beats hw_clr
        hw_set = 32'h4;
        op(1'b1, 1'b0, 1'b0, 8'hC0, 8'h00);
        check("hwset_vs_wr", 32'(regs_o[7:0]), 32'h04);
        hw_clr = 32'h4;
        idle(1);
        hw_set = '0; hw_clr = '0;
        check("hwset_vs_clr", 32'(regs_o[7:0]), 32'h04);

        // protected write without unlock
        op(1'b1, 1'b0, 1'b0, 8'hD0, 8'hFF);
        check("prot_blocked", 32'(regs_o[23:16]), 32'h5A);
        check("prot_viol_pulse", 32'(viol_o), 32'd1);
        idle(1);
        check("prot_viol_end", 32'(viol_o), 32'd0);

        // unlock then protected write
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'hAA);
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'h55);
        check("open_after_key", 32'(ta_open_o), 32'd1);
        op(1'b1, 1'b0, 1'b0, 8'hD0, 8'hFF);
        check("prot_written", 32'(regs_o[23:16]), 32'hFF);
        check("open_closed", 32'(ta_open_o), 32'd0);
        check("model_slot2", 32'(m_regs[2]), 32'hFF);
        op(1'b1, 1'b0, 1'b0, 8'hD0, 8'h00);
        check("second_blocked", 32'(regs_o[23:16]), 32'hFF);
        check("second_viol", 32'(viol_o), 32'd1);

        // window expiry
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'hAA);
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'h55);
        idle(3);
        check("window_still_open", 32'(ta_open_o), 32'd1);
        idle(1);
        check("window_expired", 32'(ta_open_o), 32'd0);
        op(1'b1, 1'b0, 1'b0, 8'hD0, 8'h12);
        check("expired_blocked", 32'(regs_o[23:16]), 32'hFF);

        // interrupted key sequence
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'hAA);
        op(1'b1, 1'b0, 1'b0, 8'hC0, 8'h11);
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'h55);
        check("broken_seq", 32'(ta_open_o), 32'd0);
        check("broken_seq_wr", 32'(regs_o[7:0]), 32'h11);

        // reset while open
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'hAA);
        op(1'b1, 1'b0, 1'b0, 8'hC7, 8'h55);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_open", 32'(ta_open_o), 32'd0);
        check("rst_regs", regs_o, 32'h3C5A005A);

        // hardware-set flag then two reads of slot1
        hw_set = 32'h100;
        idle(1);
        hw_set = '0;
        op(1'b0, 1'b1, 1'b0, 8'hC8, 8'h00);
        check("flag_rd1", 32'(bus.sfr_bank_data_o), 32'h01);
        op(1'b0, 1'b1, 1'b0, 8'hC8, 8'h00);
`ifdef CORE_SFR_BANK_RDCLR_EN
        check("flag_rd2", 32'(bus.sfr_bank_data_o), 32'h00);
`else
        check("flag_rd2", 32'(bus.sfr_bank_data_o), 32'h01);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       w, r, b;
            logic [7:0] a, d;
            int sel;
            rst    = ($urandom_range(0, 299) == 0);
            hw_set = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            hw_clr = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 2) == 0);
            d = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 5);
            case (sel)
                0: begin a = 8'hC7; b = 1'b0; d = 8'hAA; end
                1: begin a = 8'hC7; b = 1'b0; d = ($urandom_range(0, 3) == 0) ? d : 8'h55; end
                2: a = 8'hD0 + 8'($urandom_range(0, 7));
                3: a = 8'($urandom_range(0, 255));
                default: a = 8'hC0 + 8'($urandom_range(0, 31));
            endcase
            if (!b && sel >= 2 && $urandom_range(0, 1) == 0) a = {a[7:3], 3'b000};
            op(w, r, b, a, d);
        end
        rst = 1'b0; hw_set = '0; hw_clr = '0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
